// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040001c;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StHold,
        StStep,
        StFault
    } fetch_state_e;

endpackage

// File: rtl/ifetch_timer.sv
// Clearable saturating cycle counter; flags expiry once it has counted TIMEOUT-1.
module ifetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: fetches the word at pc_in over req/ack, hands it to decode
// over valid/ready and pulses pc_step once decode has taken it.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc_in,
    output logic               pc_step,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    output logic [CNT_W-1:0]   fetch_count,
    output logic               fault
);

    fetch_state_e state_q, state_d;

    logic               pc_step_q, pc_step_d;
    logic               imem_req_q, imem_req_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        instr_pc_q, instr_pc_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic               fault_q, fault_d;

    logic timer_clr, timer_en, timer_expired;

    ifetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        pc_step_d     = pc_step_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;
        fault_d       = fault_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            // In STEP the PC register has already moved, so both exits sample the new PC.
            StIdle, StStep: begin
                pc_step_d = 1'b0;
                if (pc_in[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = StFault;
                end else begin
                    imem_addr_d = pc_in;
                    imem_req_d  = 1'b1;
                    timer_clr   = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = imem_addr_q;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    fetch_count_d = fetch_count_q + CNT_W'(1);
                    state_d       = StHold;
                end else if (timer_expired) begin
                    imem_req_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = StFault;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_step_d     = 1'b1;
                    state_d       = StStep;
                end
            end
            StFault: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                pc_step_d     = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                pc_step_d     = 1'b0;
                fault_d       = 1'b1;
                state_d       = StFault;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_step_q     <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            fetch_count_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_step_q     <= pc_step_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
            fault_q       <= fault_d;
        end
    end

    assign pc_step     = pc_step_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = fetch_count_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a transaction-level model checked every cycle plus literal
// expectations at the key points of each scenario.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040001c;
    localparam int unsigned TIMEOUT  = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_step;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [15:0] fetch_count;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment controls for the PC register stand-in.
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        branch_en;
    logic [31:0] branch_target;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_step     (pc_step),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fetch_count (fetch_count),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: updates on negedge, steps by 4 or branches when pc_step is high.
    always @(negedge clk) begin
        if (pc_load) pc_in = pc_load_val;
        else if (pc_step) pc_in = branch_en ? branch_target : pc_in + 32'd4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a fetch is either outstanding, waiting for decode, or about to be issued.
    logic        m_dead, m_req, m_valid, m_step;
    logic [31:0] m_addr, m_instr, m_ipc;
    logic [15:0] m_cnt;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dead <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0; m_step <= 1'b0;
            m_addr <= 32'h0; m_instr <= 32'h0; m_ipc <= RESET_PC; m_cnt <= 16'h0; m_wait <= 0;
        end else if (m_dead) begin
            m_req <= 1'b0;
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_ipc   <= m_addr;
                m_valid <= 1'b1;
                m_req   <= 1'b0;
                m_cnt   <= m_cnt + 16'd1;
            end else if (m_wait == TIMEOUT - 1) begin
                m_req  <= 1'b0;
                m_dead <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_valid) begin
            if (instr_ready) begin
                m_valid <= 1'b0;
                m_step  <= 1'b1;
            end
        end else begin
            m_step <= 1'b0;
            if (pc_in[1:0] != 2'b00) begin
                m_dead <= 1'b1;
            end else begin
                m_addr <= pc_in;
                m_req  <= 1'b1;
                m_wait <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_pc_step", 32'(pc_step), 32'(m_step));
        check("m_imem_req", 32'(imem_req), 32'(m_req));
        check("m_imem_addr", imem_addr, m_addr);
        check("m_instr_valid", 32'(instr_valid), 32'(m_valid));
        check("m_instr", instr, m_instr);
        check("m_instr_pc", instr_pc, m_ipc);
        check("m_fetch_count", 32'(fetch_count), 32'(m_cnt));
        check("m_fault", 32'(fault), 32'(m_dead));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        pc_load = 1'b1; pc_load_val = RESET_PC; branch_en = 1'b0; branch_target = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_instr_pc", instr_pc, RESET_PC);
        check("rst_fetch_count", 32'(fetch_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Back-to-back fetch: ack and ready on the first possible edges.
        #9;
        rst_n = 1'b1; pc_load = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h11111111; instr_ready = 1'b1;
        cyc();
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'h0040001c);
        cyc();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", instr, 32'h11111111);
        check("t1_count", 32'(fetch_count), 32'd1);
        imem_ack = 1'b0;
        cyc();
        check("t1_step", 32'(pc_step), 32'd1);
        cyc();
        check("t1_step_once", 32'(pc_step), 32'd0);
        check("t1_next_addr", imem_addr, 32'h00400020);

        // Ack delayed by five cycles; ready held high while nothing is valid.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_req_held", 32'(imem_req), 32'd1);
            check("t2_addr_held", imem_addr, 32'h00400020);
        end
        imem_ack = 1'b1; imem_rdata = 32'h8C220004; instr_ready = 1'b0;
        cyc();
        check("t2_instr", instr, 32'h8C220004);
        check("t2_instr_pc", instr_pc, 32'h00400020);
        check("t2_fault", 32'(fault), 32'd0);
        imem_ack = 1'b0;

        // Decode stall for four cycles, with a stray ack while nothing is requested.
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t3_valid_held", 32'(instr_valid), 32'd1);
            check("t3_instr_held", instr, 32'h8C220004);
            check("t3_pc_held", instr_pc, 32'h00400020);
            check("t3_no_step", 32'(pc_step), 32'd0);
            if (i == 0) begin imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF; end
            if (i == 1) imem_ack = 1'b0;
        end
        instr_ready = 1'b1; branch_en = 1'b1; branch_target = 32'h00400040;
        cyc();
        check("t3_step", 32'(pc_step), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hA5A5A5A5;
        cyc();
        check("t4_branch_addr", imem_addr, 32'h00400040);
        check("t4_stray_count", 32'(fetch_count), 32'd2);
        branch_en = 1'b0;
        cyc();
        check("t4_instr", instr, 32'hA5A5A5A5);
        check("t4_count", 32'(fetch_count), 32'd3);
        imem_ack = 1'b0; instr_ready = 1'b0;

        // Asynchronous reset while holding an instruction.
        #1 rst_n = 1'b0; pc_load = 1'b1; pc_load_val = 32'h00400100;
        #1;
        check("t5_rst_valid", 32'(instr_valid), 32'd0);
        check("t5_rst_instr", instr, 32'h0);
        check("t5_rst_instr_pc", instr_pc, RESET_PC);
        check("t5_rst_count", 32'(fetch_count), 32'd0);
        check("t5_rst_req", 32'(imem_req), 32'd0);
        #13;
        rst_n = 1'b1; pc_load = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h22222222; instr_ready = 1'b1;
        cyc();
        check("t5_restart_addr", imem_addr, 32'h00400100);
        check("t5_restart_count", 32'(fetch_count), 32'd0);
        cyc();
        check("t5_count_one", 32'(fetch_count), 32'd1);
        imem_ack = 1'b0;
        cyc();
        cyc();
        check("t6_addr", imem_addr, 32'h00400104);

        // No ack: sixteen cycles in REQ, then fault.
        for (int i = 0; i < 15; i++) begin
            cyc();
            check("t6_req_waiting", 32'(imem_req), 32'd1);
            check("t6_no_fault", 32'(fault), 32'd0);
        end
        cyc();
        check("t6_req_dropped", 32'(imem_req), 32'd0);
        check("t6_fault", 32'(fault), 32'd1);
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t6_fault_sticky", 32'(fault), 32'd1);
            check("t6_fault_no_req", 32'(imem_req), 32'd0);
        end

        // Misaligned PC at an IDLE exit.
        rst_n = 1'b0; pc_load = 1'b1; pc_load_val = 32'h00400022; imem_ack = 1'b0;
        cyc();
        rst_n = 1'b1; pc_load = 1'b0; imem_ack = 1'b1;
        cyc();
        check("t7_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t7_never_req", 32'(imem_req), 32'd0);
            check("t7_no_valid", 32'(instr_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
